// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the uart receive FIFO and the io registers that expose it.
// The io block decodes these addresses; the FIFO itself only uses the depth.
package uart_rx_fifo_pkg;

  localparam int UART_RX_FIFO_DEPTH = 16;

  // io register map for the receive path
  localparam logic [7:0] IO_RX_DATA   = 8'h10;  // read: head byte (show-ahead)
  localparam logic [7:0] IO_RX_STATUS = 8'h11;  // read: {count, overflow, full, empty}
  localparam logic [7:0] IO_RX_CTRL   = 8'h12;  // write: pop / clear strobes

  localparam int RX_CTRL_POP_BIT   = 0;
  localparam int RX_CTRL_CLEAR_BIT = 1;

  localparam int RX_CNT_W = $clog2(UART_RX_FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [RX_CNT_W-1:0] count;
    logic                overflow;
    logic                full;
    logic                empty;
  } rx_status_t;

endpackage

// File: rtl/uart_rx_fifo_pulse_sync.sv
// Multi-flop synchronizer for a slow-domain level plus rising-edge detect.
// pulse is high for exactly one clk per rising edge of level.
module pulse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  // [STAGES-1:0] synchronize, [STAGES] remembers the previous synced value
  logic [STAGES:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-1:0], level};
  end

  assign pulse = sync_q[STAGES-1] & ~sync_q[STAGES];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer between the uart and io: pushes on rx_done rising edge,
// pops on a synchronized pop_req rising edge, show-ahead head byte.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        pop_req,
  input  logic        clear,
  output logic [7:0]  rd_data,
  output logic [AW:0] count,
  output logic        empty,
  output logic        full,
  output logic        overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rx_done_q;
  logic          push, pop, do_push, do_pop;

  pulse_sync #(.STAGES(2)) u_pop_sync (
    .clk   (clk),
    .rst   (rst),
    .level (pop_req),
    .pulse (pop)
  );

  assign push  = rx_done & ~rx_done_q;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop  & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        if (do_push && !do_pop)      count <= count + 1'b1;
        else if (!do_push && do_pop) count <= count - 1'b1;
        if (push && !do_push) overflow <= 1'b1;
      end
    end
  end

  // Storage is plain registers without reset; contents behind rd_ptr are don't-care.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_data;
  end

  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for push/pop/clear sequences
// plus hand-timed sequences for coincident events and reset.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done, pop_req, clear;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       empty, full, overflow;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .pop_req  (pop_req),
    .clear    (clear),
    .rd_data  (rd_data),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {V_IDLE, V_PUSH, V_POP, V_CLEAR} vop_e;

  typedef struct {
    vop_e       op;
    logic [7:0] din;
    int         cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(vop_e op, logic [7:0] din, int cnt, logic emp,
                              logic ful, logic ovf, logic [7:0] rd);
    vec_t v;
    v.op = op; v.din = din; v.cnt = cnt; v.emp = emp;
    v.ful = ful; v.ovf = ovf; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int idx, input int cnt,
                           input logic emp, input logic ful, input logic ovf,
                           input logic [7:0] rd);
    chk({tag, ".count"}, idx, 32'(count), 32'(cnt));
    chk({tag, ".empty"}, idx, 32'(empty), 32'(emp));
    chk({tag, ".full"}, idx, 32'(full), 32'(ful));
    chk({tag, ".overflow"}, idx, 32'(overflow), 32'(ovf));
    chk({tag, ".rd_data"}, idx, 32'(rd_data), 32'(rd));
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // pop lands on the 3rd posedge after the rise; idle long enough to re-arm
  task automatic pop_one();
    @(negedge clk);
    pop_req = 1'b1;
    repeat (3) @(negedge clk);
    pop_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; pop_req = 1'b0; clear = 1'b0;

    // vector table
    vecs.push_back(mk(V_IDLE, 8'h00, 0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(V_PUSH, 8'hA5, 1, 0, 0, 0, 8'hA5));
    vecs.push_back(mk(V_POP,  8'h00, 0, 1, 0, 0, 8'h00));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(V_PUSH, 8'(i), i + 1, 0, i == 15, 0, 8'h00));
    vecs.push_back(mk(V_PUSH, 8'hFF, 16, 0, 1, 1, 8'h00));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(V_POP, 8'h00, 15 - i, i == 15, 0, 1,
                        (i == 15) ? 8'h00 : 8'(i + 1)));
    vecs.push_back(mk(V_CLEAR, 8'h00, 0, 1, 0, 0, 8'h00));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(V_PUSH, 8'(8'h10 + i), i + 1, 0, 0, 0, 8'h10));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(V_POP, 8'h00, 9 - i, i == 9, 0, 0,
                        (i == 9) ? 8'h00 : 8'(8'h11 + i)));
    for (int k = 0; k < 12; k++)
      vecs.push_back(mk(V_PUSH, 8'(8'h20 + k), k + 1, 0, 0, 0, 8'h20));
    for (int k = 0; k < 12; k++)
      vecs.push_back(mk(V_POP, 8'h00, 11 - k, k == 11, 0, 0,
                        (k == 11) ? 8'h00 : 8'(8'h21 + k)));

    repeat (3) @(negedge clk);
    chk_state("reset", 0, 0, 1, 0, 0, 8'h00);
    rst = 1'b0;

    foreach (vecs[i]) begin
      case (vecs[i].op)
        V_PUSH:  push_byte(vecs[i].din);
        V_POP:   pop_one();
        V_CLEAR: do_clear();
        default: @(negedge clk);
      endcase
      chk_state("vec", i, vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].ovf, vecs[i].rd);
    end

    // rx_done held high for 10 clks pushes one byte
    @(negedge clk);
    rx_data = 8'h77; rx_done = 1'b1;
    repeat (10) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
    chk_state("hold", 0, 1, 0, 0, 0, 8'h77);
    do_clear();

    // full FIFO: push and pop on the same edge
    for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i));
    chk_state("full_pp_pre", 0, 16, 0, 1, 0, 8'h40);
    @(negedge clk);
    pop_req = 1'b1;
    repeat (2) @(negedge clk);
    rx_data = 8'hEE; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    chk_state("full_pp", 0, 16, 0, 1, 0, 8'h41);
    pop_req = 1'b0;
    repeat (3) @(negedge clk);
    do_clear();

    // empty FIFO: push and pop on the same edge, pop ignored
    @(negedge clk);
    pop_req = 1'b1;
    repeat (2) @(negedge clk);
    rx_data = 8'h5A; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    chk_state("empty_pp", 0, 1, 0, 0, 0, 8'h5A);
    pop_req = 1'b0;
    repeat (3) @(negedge clk);
    do_clear();

    // build count=7 with overflow set, then clear concurrent with a push
    for (int i = 0; i < 17; i++) push_byte(8'(8'h60 + i));
    for (int i = 0; i < 9; i++) pop_one();
    chk_state("pre_clear", 0, 7, 0, 0, 1, 8'h69);
    @(negedge clk);
    rx_data = 8'h99; rx_done = 1'b1; clear = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; clear = 1'b0;
    chk_state("clear_push", 0, 0, 1, 0, 0, 8'h00);

    // pop on empty is ignored
    pop_one();
    chk_state("pop_empty", 0, 0, 1, 0, 0, 8'h00);

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push_byte(8'(8'h80 + i));
    chk_state("pre_rst", 0, 5, 0, 0, 0, 8'h80);
    #2 rst = 1'b1;
    #1 chk_state("async_rst", 0, 0, 1, 0, 0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    push_byte(8'h3C);
    chk_state("post_rst", 0, 1, 0, 0, 0, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
